sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
- Bit-serial subtractor: computes num1 - num2 for two unsigned WIDTH-bit operands, LSB first, one bit per clock.
- Produces a (WIDTH+1)-bit two's-complement difference plus zero and negative flags.
- Companion to the combinational adder: same operand/flag conventions, inverse operation.
- Uses a start/busy/done handshake so it can sit behind the ALU operation sequencer.

Parameters:
- WIDTH, 3, operand width in bits. Legal values 2..16. The result is WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- num1  input  WIDTH  minuend (unsigned); sampled with an accepted start
- num2  input  WIDTH  subtrahend (unsigned); sampled with an accepted start
- busy  output  1  high while an operation is in SHIFT or DONE
- done  output  1  one-cycle pulse; result and flags are valid and updated
- result  output  WIDTH+1  two's-complement num1-num2; held until the next done
- zeroflag  output  1  1 when result == 0; updated with result
- negflag  output  1  1 when num1 < num2 (final borrow) = result[WIDTH]

Behaviour:
- Reset is asynchronous: rst_n=0 immediately forces state=IDLE and clears result, zeroflag, negflag, busy, done and all internal registers to 0. Release is synchronous to the next clk edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge latches num1/num2 into shift registers A/B, clears borrow, clears bit counter cnt, clears the difference shift register D, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each edge:
  - d = A[0]^B[0]^borrow.
  - borrow_next = (~A[0]&B[0]) | (~(A[0]^B[0])&borrow).
  - D shifts right with d entering at bit WIDTH-1; A and B shift right; cnt increments.
  - On the edge where cnt==WIDTH-1, go to DONE. In the same edge, load result = {borrow_next, D_final}, zeroflag = (that value == 0) and negflag = borrow_next.
- DONE: done=1 for exactly this one cycle; the next edge moves unconditionally to IDLE.
- busy = (state != IDLE). done = (state == DONE). Both are registered-state decodes with no combinational path from start.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+WIDTH. Minimum start-to-start period is WIDTH+2 cycles.
- start asserted while busy=1 is ignored and not queued. num1/num2 changes while busy have no effect.
- result, zeroflag and negflag change only on the done-entering edge or on reset. They hold between operations and do not glitch during SHIFT.
- start held high continuously gives back-to-back operations, each re-sampling the operands at the IDLE edge.
- Width rule: the range is -(2^WIDTH-1)..(2^WIDTH-1), which always fits in WIDTH+1 bits. There is no overflow flag.
- Reset mid-operation (rst_n low during SHIFT): the operation is abandoned, outputs clear to 0 and no done is generated.

Test Plan:
- Reset values: rst_n=0 then release, start=0 -> busy=0, done=0, result=0000, zeroflag=0, negflag=0.
- 101 - 011 with start pulsed at edge k -> busy high after edge k; done only in the cycle after edge k+3; result=0010, zeroflag=0, negflag=0.
- Zero and negative cases:
  - 011 - 011 -> result=0000, zeroflag=1, negflag=0.
  - 000 - 111 -> result=1001, negflag=1, zeroflag=0.
- start held high, operands changed mid-operation (110-001, then inputs switched to 001-110 during SHIFT) -> first done gives 0101. The second operation starts 5 cycles after the first and gives 1011. Inputs changed during busy are ignored.
- Reset mid-operation: rst_n low for 1 ns during the 2nd SHIFT cycle of 111-001 -> outputs are 0 immediately, no done follows, and the next start operates normally.
- Exhaustive check: all 64 (num1,num2) pairs, num1 and num2 each 000..111 -> result == num1-num2 (4-bit two's complement), zeroflag == (num1==num2), negflag == (num1<num2). Each pair is logged in "sub.txt" in the same format as the adder log.

Source files
------------

// File: rtl/sub_serial.sv
// sub_serial: bit-serial unsigned subtractor, LSB first, one bit per clock.
// Produces a (WIDTH+1)-bit two's-complement difference plus zero/negative flags.
// Handshake: start (sampled in IDLE) -> busy while SHIFT/DONE -> one-cycle done.
module sub_serial #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             zeroflag,
    output logic             negflag
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             diff_bit;
    logic             borrow_nxt;
    logic [WIDTH-1:0] d_shift;
    logic [WIDTH:0]   final_val;
    logic             last_bit;

    // One full-subtractor slice on the current LSBs of the operand shift registers
    always_comb begin
        diff_bit   = a[0] ^ b[0] ^ borrow;
        borrow_nxt = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow);
        d_shift    = {diff_bit, d[WIDTH-1:1]};
        final_val  = {borrow_nxt, d_shift};
        last_bit   = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            d        <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zeroflag <= 1'b0;
            negflag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a      <= num1;
                        b      <= num2;
                        d      <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a      <= a >> 1;
                    b      <= b >> 1;
                    d      <= d_shift;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CW'(1);
                    // Final bit: publish result and flags together with done
                    if (last_bit) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= final_val;
                        zeroflag <= (final_val == RW'(0));
                        negflag  <= borrow_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Directed testbench for sub_serial (WIDTH=3).
module tb_sub_serial;

    localparam int unsigned W = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         busy;
    logic         done;
    logic [W:0]   result;
    logic         zeroflag;
    logic         negflag;

    int total;
    int bad;

    sub_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num1     (num1),
        .num2     (num2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zeroflag (zeroflag),
        .negflag  (negflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] n1;
        logic [W-1:0] n2;
        logic [W:0]   r;
        logic         z;
        logic         n;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Launch one operation and check latency, hold behaviour and final outputs
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] er, input logic ez, input logic en,
                          input string name);
        logic [W:0] prev;
        logic       stable;
        logic       early;
        @(negedge clk);
        num1  = a;
        num2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk({name, ".busy"}, 32'(busy), 32'd1);
        start  = 1'b0;
        prev   = result;
        stable = 1'b1;
        early  = 1'b0;
        for (int i = 1; i <= int'(W); i++) begin
            @(posedge clk);
            #1;
            if (i < int'(W)) begin
                if (done) early = 1'b1;
                if (result !== prev) stable = 1'b0;
            end else begin
                chk({name, ".done"}, 32'(done), 32'd1);
                chk({name, ".result"}, 32'(result), 32'(er));
                chk({name, ".zero"}, 32'(zeroflag), 32'(ez));
                chk({name, ".neg"}, 32'(negflag), 32'(en));
            end
        end
        chk({name, ".early_done"}, 32'(early), 32'd0);
        chk({name, ".hold"}, 32'(stable), 32'd1);
        @(posedge clk);
        #1;
        chk({name, ".idle_done"}, 32'(done), 32'd0);
        chk({name, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W:0] model;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        num1  = '0;
        num2  = '0;

        vecs[0] = '{3'b101, 3'b011, 4'b0010, 1'b0, 1'b0};
        vecs[1] = '{3'b011, 3'b011, 4'b0000, 1'b1, 1'b0};
        vecs[2] = '{3'b000, 3'b111, 4'b1001, 1'b0, 1'b1};
        vecs[3] = '{3'b111, 3'b000, 4'b0111, 1'b0, 1'b0};
        vecs[4] = '{3'b110, 3'b001, 4'b0101, 1'b0, 1'b0};
        vecs[5] = '{3'b001, 3'b110, 4'b1011, 1'b0, 1'b1};
        vecs[6] = '{3'b100, 3'b101, 4'b1111, 1'b0, 1'b1};
        vecs[7] = '{3'b010, 3'b000, 4'b0010, 1'b0, 1'b0};
        vecs[8] = '{3'b111, 3'b111, 4'b0000, 1'b1, 1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.zero", 32'(zeroflag), 32'd0);
        chk("rst.neg", 32'(negflag), 32'd0);

        // Directed table
        for (int i = 0; i < 9; i++)
            run_op(vecs[i].n1, vecs[i].n2, vecs[i].r, vecs[i].z, vecs[i].n,
                   $sformatf("vec%0d", i));

        // Back-to-back with start held and operands changed while busy
        @(negedge clk);
        num1  = 3'b110;
        num2  = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        num1 = 3'b001;
        num2 = 3'b110;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b.done%0d", i), 32'(done), (i == 3 || i == 8) ? 32'd1 : 32'd0);
            if (i == 3) chk("b2b.first", 32'(result), 32'h5);
            if (i == 4) chk("b2b.gap_busy", 32'(busy), 32'd0);
            if (i == 5) chk("b2b.restart_busy", 32'(busy), 32'd1);
            if (i == 8) begin
                chk("b2b.second", 32'(result), 32'hB);
                chk("b2b.second_neg", 32'(negflag), 32'd1);
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("b2b.end_busy", 32'(busy), 32'd0);

        // Reset during the second SHIFT cycle abandons the operation
        @(negedge clk);
        num1  = 3'b111;
        num2  = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        chk("mid_rst.result", 32'(result), 32'd0);
        chk("mid_rst.busy", 32'(busy), 32'd0);
        chk("mid_rst.neg", 32'(negflag), 32'd0);
        #0.5;
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) seen = 1'b1;
            end
            chk("mid_rst.no_done", 32'(seen), 32'd0);
        end
        run_op(3'b111, 3'b001, 4'b0110, 1'b0, 1'b0, "post_rst");

        // Exhaustive sweep against an arithmetic model
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                model = 4'(x) - 4'(y);
                run_op(3'(x), 3'(y), model, (x == y), (x < y),
                       $sformatf("ex_%0d_%0d", x, y));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
